// File: rtl/mul_iter_ctrl.sv
// Iterative sign-magnitude shift-add multiplier for the EXE stage.
// Accepts MUL.W / MULH.W / MULH.WU and returns the selected 32-bit half over valid/ready.
module mul_iter_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_op_i,
  input  logic [31:0]      in_a_i,
  input  logic [31:0]      in_b_i,
  input  logic [TAG_W-1:0] in_tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_res_o,
  output logic [TAG_W-1:0] out_tag_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic [31:0]      ma_q, ma_d;
  logic [31:0]      mb_q, mb_d;
  logic [1:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [63:0]      prod_q, prod_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [31:0]      res_q, res_d;

  logic             reqSigned;
  logic [63:0]      addend;
  logic [63:0]      prodNext;
  logic [63:0]      finalProd;

  assign in_ready_o  = (state_q == IDLE) && resetn_i && !flush_i;
  assign out_valid_o = (state_q == DONE);
  assign out_res_o   = res_q;
  assign out_tag_o   = tag_q;

  // Only MULH.W works on signed operands; everything else is unsigned magnitude.
  assign reqSigned = (in_op_i == 2'b01);
  assign addend    = mb_q[0] ? ({32'b0, ma_q} << cnt_q) : 64'd0;
  assign prodNext  = prod_q + addend;
  assign finalProd = sign_q ? -prodNext : prodNext;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    op_d    = op_q;
    tag_d   = tag_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    res_d   = res_q;

    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_o) begin
          sign_d  = reqSigned && (in_a_i[31] ^ in_b_i[31]);
          ma_d    = (reqSigned && in_a_i[31]) ? -in_a_i : in_a_i;
          mb_d    = (reqSigned && in_b_i[31]) ? -in_b_i : in_b_i;
          op_d    = in_op_i;
          tag_d   = in_tag_i;
          prod_d  = 64'd0;
          cnt_d   = 5'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        prod_d = prodNext;
        mb_d   = mb_q >> 1;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          res_d   = (op_q == 2'b01 || op_q == 2'b10) ? finalProd[63:32] : finalProd[31:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides any accept, progress or handshake decided above.
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      ma_q    <= 32'd0;
      mb_q    <= 32'd0;
      op_q    <= 2'd0;
      tag_q   <= '0;
      prod_q  <= 64'd0;
      cnt_q   <= 5'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_mul_iter_ctrl.sv
// Directed and randomized checks for mul_iter_ctrl against a 64-bit multiply reference.
module tb_mul_iter_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_tag;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] expRes;
  } vec_t;

  vec_t vecs[8];

  mul_iter_ctrl #(.TAG_W(5)) dut (
    .clk_i(clk),
    .resetn_i(resetn),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .in_op_i(in_op),
    .in_a_i(in_a),
    .in_b_i(in_b),
    .in_tag_i(in_tag),
    .flush_i(flush),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_res_o(out_res),
    .out_tag_o(out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    else
      passCount++;
  endtask

  // Called at a negedge while idle; returns once out_valid is seen (or the bound expires).
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tag, output int lat);
    in_op = op;
    in_a = a;
    in_b = b;
    in_tag = tag;
    in_valid = 1'b1;
    #1;
    checkOutput("accept_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'b01) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p = ea * eb;
    return (op == 2'b01 || op == 2'b10) ? p[63:32] : p[31:0];
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int stable;
    bit sawValid;
    bit r;
    logic [31:0] res0;
    logic [4:0] tag0;
    logic [1:0] rop;
    logic [31:0] ra, rb, rexp;
    logic [4:0] rtag;

    vecs[0] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB};
    vecs[1] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000};
    vecs[2] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
    vecs[3] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0000};
    vecs[4] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0001};
    vecs[5] = '{2'b11, 32'h1234_5678, 32'h0000_0010, 5'd6,  32'h2345_6780};
    vecs[6] = '{2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 5'd31, 32'hFFFF_FFFF};
    vecs[7] = '{2'b10, 32'h0001_0000, 32'h0001_0000, 5'd0,  32'h0000_0001};

    resetn = 1'b0;
    in_valid = 1'b0;
    in_op = 2'b00;
    in_a = 32'd0;
    in_b = 32'd0;
    in_tag = 5'd0;
    flush = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_res", out_res, 32'd0);
    checkOutput("rst_out_tag", {27'd0, out_tag}, 32'd0);
    resetn = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, lat);
      checkOutput($sformatf("vec%0d_latency", i), lat, 32'd33);
      checkOutput($sformatf("vec%0d_res", i), out_res, vecs[i].expRes);
      checkOutput($sformatf("vec%0d_tag", i), {27'd0, out_tag}, {27'd0, vecs[i].tag});
      @(negedge clk);
    end

    // Backpressure: DONE must hold its outputs until out_ready rises.
    out_ready = 1'b0;
    applyStimulus(2'b00, 32'h0000_1234, 32'h0000_0010, 5'd7, lat);
    checkOutput("bp_latency", lat, 32'd33);
    checkOutput("bp_res", out_res, 32'h0001_2340);
    res0 = out_res;
    tag0 = out_tag;
    stable = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid && out_res == res0 && out_tag == tag0 && !in_ready) stable++;
    end
    checkOutput("bp_stable_cycles", stable, 32'd10);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 5'd9, lat);
    checkOutput("b2b_latency", lat, 32'd33);
    checkOutput("b2b_res", out_res, 32'hFFFF_FFFF);
    checkOutput("b2b_tag", {27'd0, out_tag}, 32'd9);
    @(negedge clk);

    // Flush mid-CALC: the 5*6 result must never surface.
    in_op = 2'b00;
    in_a = 32'd5;
    in_b = 32'd6;
    in_tag = 5'd2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    sawValid = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    if (out_valid) sawValid = 1'b1;
    checkOutput("flush_no_valid", {31'd0, sawValid}, 32'd0);
    applyStimulus(2'b00, 32'd9, 32'd9, 5'd4, lat);
    checkOutput("post_flush_latency", lat, 32'd33);
    checkOutput("post_flush_res", out_res, 32'h0000_0051);
    checkOutput("post_flush_tag", {27'd0, out_tag}, 32'd4);
    @(negedge clk);

    // Flush together with a request in IDLE blocks the accept.
    in_op = 2'b00;
    in_a = 32'd3;
    in_b = 32'd3;
    in_tag = 5'd8;
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    checkOutput("flush_idle_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    checkOutput("flush_idle_not_accepted", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Reset pulse mid-CALC clears outputs and returns to IDLE.
    in_op = 2'b00;
    in_a = 32'd100;
    in_b = 32'd100;
    in_tag = 5'd6;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_out_res", out_res, 32'd0);
    checkOutput("midrst_out_tag", {27'd0, out_tag}, 32'd0);
    #1;
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(2'b10, 32'h0001_0000, 32'h0001_0000, 5'd5, lat);
    checkOutput("midrst_next_latency", lat, 32'd33);
    checkOutput("midrst_next_res", out_res, 32'h0000_0001);
    @(negedge clk);

    // Randomized operations with random consumer backpressure.
    for (int n = 0; n < 1000; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra = pickOperand();
      rb = pickOperand();
      rtag = 5'($urandom_range(0, 31));
      rexp = refModel(rop, ra, rb);
      out_ready = 1'($urandom_range(0, 1));
      applyStimulus(rop, ra, rb, rtag, lat);
      if (out_res !== rexp || out_tag !== rtag || lat != 33) begin
        checkCount++;
        $display("[TB] FAIL rand%0d op=%0d a=0x%08h b=0x%08h: got res 0x%08h tag %0d lat %0d, required res 0x%08h tag %0d lat 33",
                 n, rop, ra, rb, out_res, out_tag, lat, rexp, rtag);
      end else begin
        checkCount++;
        passCount++;
      end
      r = 1'b0;
      for (int g = 0; g < 50 && !r; g++) begin
        r = 1'($urandom_range(0, 1));
        out_ready = r;
        @(negedge clk);
      end
      if (!r) begin
        out_ready = 1'b1;
        @(negedge clk);
      end
    end
    out_ready = 1'b1;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
